// File: rtl/rand_server.sv
// rand_server: one 13-bit LFSR shared by up to four requesters under round-robin arbitration,
// each draw reduced to [0, limit) by mask-and-reject. Define RAND_STATS_EN to add reject_cnt.
module rand_server #(
    parameter int unsigned     NUM_REQ = 4,
    parameter int unsigned     WIDTH   = 13,
    parameter logic [WIDTH-1:0] SEED   = 13'h000F,
    parameter int unsigned     SHIFTS  = 13
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] limit,
    output logic [NUM_REQ-1:0]       ack,
    output logic [WIDTH-1:0]         rnd_out,
    output logic [1:0]               grant_id,
    output logic                     busy
`ifdef RAND_STATS_EN
    ,
    output logic [15:0]              reject_cnt
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] GRANT = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] lfsr;
    logic [1:0]       ptr;
    logic [3:0]       cnt;

    logic [3:0]       req_pad;
    logic             pick_valid;
    logic [1:0]       pick;
    logic [1:0]       idx;

    logic [WIDTH-1:0] lim;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] cand;
    logic             accept;

    always_ff @(posedge clock) begin
        if (reset || lfsr == '0) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[WIDTH-2:0], lfsr[12] ^ lfsr[3] ^ lfsr[2] ^ lfsr[0]};
        end
    end

    // Round-robin: scan from ptr+1 upward with wrap; first asserted request wins.
    always_comb begin
        req_pad = '0;
        req_pad[NUM_REQ-1:0] = req;
        pick_valid = 1'b0;
        pick = ptr;
        idx = ptr;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = 2'((32'(ptr) + i) % NUM_REQ);
            if (!pick_valid && req_pad[idx]) begin
                pick_valid = 1'b1;
                pick = idx;
            end
        end
    end

    // Mask covers every bit up to the MSB of limit-1, so a candidate is rejected less than half the time.
    always_comb begin
        lim = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 2'(i)) begin
                lim = limit[i*WIDTH +: WIDTH];
            end
        end
        mask = lim - WIDTH'(1);
        for (int unsigned s = 1; s < WIDTH; s = s << 1) begin
            mask = mask | (mask >> s);
        end
        if (lim == '0) begin
            mask = '1;
        end
        cand   = lfsr & mask;
        accept = (lim == '0) || (cand < lim);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= 2'(NUM_REQ - 1);
            cnt      <= '0;
            grant_id <= '0;
            rnd_out  <= '0;
            ack      <= '0;
`ifdef RAND_STATS_EN
            reject_cnt <= '0;
`endif
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick;
                        cnt      <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == 4'(SHIFTS - 1)) begin
                        state <= CHECK;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        rnd_out <= cand;
                        state   <= GRANT;
                    end else begin
                        cnt   <= '0;
                        state <= SHIFT;
`ifdef RAND_STATS_EN
                        if (reject_cnt != '1) begin
                            reject_cnt <= reject_cnt + 16'd1;
                        end
`endif
                    end
                end
                GRANT: begin
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        ack[i] <= (grant_id == 2'(i));
                    end
                    ptr   <= grant_id;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rand_server.sv
// Scoreboard bench for rand_server: stimulus queues expected grants, a negedge monitor checks each ack.
module tb_rand_server;

    localparam int          NUM_REQ = 4;
    localparam int          WIDTH   = 13;
    localparam int          SHIFTS  = 13;
    localparam logic [12:0] SEED    = 13'h000F;
    localparam int          HDEPTH  = 8192;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req   = '0;
    logic [51:0] limit = '0;
    logic [3:0]  ack;
    logic [12:0] rnd_out;
    logic [1:0]  grant_id;
    logic        busy;
`ifdef RAND_STATS_EN
    logic [15:0] reject_cnt;
`endif

    always #5 clock = ~clock;

    rand_server #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .SEED    (SEED),
        .SHIFTS  (SHIFTS)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .limit    (limit),
        .ack      (ack),
        .rnd_out  (rnd_out),
        .grant_id (grant_id),
        .busy     (busy)
`ifdef RAND_STATS_EN
        ,
        .reject_cnt (reject_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference LFSR: taps at bits 12,3,2,0 as a parity over a tap mask.
    function automatic logic [12:0] step(input logic [12:0] v);
        if (v == 13'h0) return SEED;
        return {v[11:0], ^(v & 13'h100D)};
    endfunction

    function automatic logic [12:0] mask_for(input logic [12:0] l);
        int b;
        if (l == 13'h0) return 13'h1FFF;
        b = 0;
        while ((1 << b) < int'(l)) b++;
        return 13'((1 << b) - 1);
    endfunction

    logic [12:0] hist [0:HDEPTH-1];
    logic [12:0] m_lfsr = SEED;
    int          edge_n = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_lfsr = SEED;
            edge_n = 0;
        end else begin
            m_lfsr = step(m_lfsr);
            edge_n++;
        end
        if (edge_n < HDEPTH) hist[edge_n] = m_lfsr;
    end

    typedef struct {
        int          id;
        logic [12:0] lim;
        int          e0;
    } txn_t;

    txn_t        sbq[$];
    int          prev_ack = -1;
    int          exp_rej  = 0;
    txn_t        mt;
    int          me;
    int          mc;
    logic [12:0] mm;
    logic [12:0] mcand;

    always @(negedge clock) begin
        if (reset) begin
            prev_ack = -1;
            exp_rej  = 0;
        end else if (ack != 4'b0) begin
            check("ack_onehot", 32'($onehot(ack)), 32'd1);
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack=%b expected no ack", ack);
            end else begin
                mt = sbq.pop_front();
                me = (mt.e0 > prev_ack + 1) ? mt.e0 : prev_ack + 1;
                mm = mask_for(mt.lim);
                mc = me + SHIFTS;
                mcand = '0;
                for (int k = 0; k < 64 && mc < HDEPTH; k++) begin
                    mcand = hist[mc] & mm;
                    if (mt.lim == 13'h0 || mcand < mt.lim) break;
                    mc += SHIFTS + 1;
                    exp_rej++;
                end
                check("ack_id", 32'(ack), 32'(1) << mt.id);
                check("grant_id", 32'(grant_id), 32'(mt.id));
                check("ack_edge", 32'(edge_n), 32'(mc + 2));
                check("rnd_out", 32'(rnd_out), 32'(mcand));
                check("busy_at_ack", 32'(busy), 32'd0);
                prev_ack = mc + 2;
            end
        end
    end

    int remaining [0:3] = '{0, 0, 0, 0};

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input int id, input logic [12:0] lim);
        txn_t t;
        t.id  = id;
        t.lim = lim;
        t.e0  = edge_n + 1;
        sbq.push_back(t);
    endtask

    task automatic set_limit(input int id, input logic [12:0] lim);
        limit[id*WIDTH +: WIDTH] = lim;
    endtask

    // Requesters drop req on seeing their final ack.
    task automatic run_until_done(input int budget);
        int cyc;
        cyc = 0;
        while ((remaining[0] + remaining[1] + remaining[2] + remaining[3] != 0 || sbq.size() != 0)
               && cyc < budget) begin
            @(negedge clock);
            for (int i = 0; i < 4; i++) begin
                if (ack[i] && remaining[i] > 0) begin
                    remaining[i]--;
                    if (remaining[i] == 0) req[i] = 1'b0;
                end
            end
            cyc++;
        end
        if (cyc >= budget) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d acks outstanding expected 0", sbq.size());
            sbq.delete();
            req = '0;
            for (int i = 0; i < 4; i++) remaining[i] = 0;
        end
        tick(1);
    endtask

    initial begin
        tick(3);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rnd", 32'(rnd_out), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_lfsr", 32'(dut.lfsr), 32'h000F);

        // Seed ones shift up until the register fills, then the first zero feeds back.
        reset = 1'b0;
        tick(9);
        check("lfsr_9", 32'(dut.lfsr), 32'h1FFF);
        tick(1);
        check("lfsr_10", 32'(dut.lfsr), 32'h1FFE);

        set_limit(0, 13'd0);
        req[0] = 1'b1;
        remaining[0] = 1;
        push(0, 13'd0);
        tick(2);
        check("busy_in_shift", 32'(busy), 32'd1);
        run_until_done(100);

        for (int i = 0; i < 4; i++) begin
            set_limit(i, 13'd0);
            remaining[i] = 3;
        end
        req = 4'b1111;
        for (int r = 0; r < 3; r++) begin
            push(1, 13'd0);
            push(2, 13'd0);
            push(3, 13'd0);
            push(0, 13'd0);
        end
        run_until_done(400);

        set_limit(1, 13'd1);
        req[1] = 1'b1;
        remaining[1] = 4;
        for (int r = 0; r < 4; r++) push(1, 13'd1);
        run_until_done(200);
`ifdef RAND_STATS_EN
        check("stats_limit1", 32'(reject_cnt), 32'd0);
`endif

        set_limit(1, 13'd5);
        req[1] = 1'b1;
        remaining[1] = 100;
        for (int r = 0; r < 100; r++) push(1, 13'd5);
        run_until_done(6000);
`ifdef RAND_STATS_EN
        check("stats_limit5", 32'(reject_cnt), 32'(exp_rej));
`endif

        set_limit(1, 13'd0);
        set_limit(2, 13'd0);
        set_limit(3, 13'd0);
        req = 4'b1100;
        remaining[2] = 1;
        remaining[3] = 1;
        push(2, 13'd0);
        push(3, 13'd0);
        tick(6);
        req[2] = 1'b0;
        run_until_done(200);

        req[0] = 1'b1;
        tick(5);
        check("busy_before_abort", 32'(busy), 32'd1);
        reset = 1'b1;
        req = '0;
        tick(1);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_rnd", 32'(rnd_out), 32'd0);
        check("abort_grant", 32'(grant_id), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_lfsr", 32'(dut.lfsr), 32'h000F);
`ifdef RAND_STATS_EN
        check("abort_stats", 32'(reject_cnt), 32'd0);
`endif
        reset = 1'b0;
        tick(40);

        set_limit(0, 13'd4);
        req[0] = 1'b1;
        remaining[0] = 2;
        push(0, 13'd4);
        push(0, 13'd4);
        run_until_done(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
